// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trig_pkg
// Description : Shared FSM state type and helper functions for the
//               coincidence trigger generator.
// Revision    : 1.0  initial release
// ============================================================================
package trig_pkg;

    localparam int unsigned C_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIRE    = 2'd2,
        HOLD    = 2'd3
    } trig_state_t;

    function automatic int unsigned popcount(input logic [C_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < C_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Increment a w-bit value held in a wide container, sticking at all-ones.
    function automatic logic [C_MAX_W-1:0] sat_inc(input logic [C_MAX_W-1:0] v,
                                                   input int unsigned       w);
        logic [C_MAX_W-1:0] max_v;
        max_v = (w >= C_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : (v + 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : trig_sat_counter
// Description : Saturating event counter with synchronous active-high reset.
// Revision    : 1.0  initial release
// ============================================================================
module trig_sat_counter
    import trig_pkg::*;
#(
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    output logic [STAT_W-1:0] o_count
);

    logic [STAT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= STAT_W'(sat_inc(C_MAX_W'(r_count), STAT_W));
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/trig_coinc_gen.sv
`default_nettype none
// ============================================================================
// Module      : trig_coinc_gen
// Description : Counts masked ACK rising edges in a programmable window and
//               fires a fixed-width TRG pulse, followed by a holdoff.
//               Define TRG_REJECT_CNT_EN to add the TRG_REJECTS counter.
// Revision    : 1.0  initial release
// ============================================================================
module trig_coinc_gen
    import trig_pkg::*;
#(
    parameter int unsigned N_CH    = 12,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned WIN_W   = 4,
    parameter int unsigned TRG_LEN = 4,
    parameter int unsigned HOLD_W  = 16,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              CLK_80MHZ,
    input  logic              RESET,
    input  logic [N_CH-1:0]   ACK,
    input  logic [N_CH-1:0]   TRG_MASK,
    input  logic [CNT_W-1:0]  MIN_SCRODS_REQUIRED,
    input  logic [WIN_W-1:0]  WINDOW,
    input  logic [HOLD_W-1:0] HOLDOFF,
    input  logic              TRG_SOFT,
    output logic [N_CH-1:0]   TRG,
    output logic              TRG_BUSY,
    output logic [N_CH-1:0]   ACK_LATCHED,
`ifdef TRG_REJECT_CNT_EN
    output logic [STAT_W-1:0] TRG_REJECTS,
`endif
    output logic [STAT_W-1:0] TRG_STATISTICS
);

    localparam int unsigned C_PULSE_W = (TRG_LEN > 1) ? $clog2(TRG_LEN) : 1;

    trig_state_t          r_state;
    trig_state_t          w_state_nxt;
    logic [N_CH-1:0]      r_ack_q;
    logic [N_CH-1:0]      r_coll;
    logic [N_CH-1:0]      r_trg_mask;
    logic [N_CH-1:0]      r_ack_latched;
    logic [WIN_W-1:0]     r_win_cnt;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [C_PULSE_W-1:0] r_pulse_cnt;

    logic [N_CH-1:0]      w_edge;
    logic [N_CH-1:0]      w_coll_all;
    int unsigned          w_thr;
    logic                 w_meet;
    logic                 w_fire_go;
    logic                 w_collect_go;
    logic                 w_expire;
    logic                 w_miss;

    assign w_edge     = ACK & ~r_ack_q & TRG_MASK;
    // Outside COLLECT the stale collection register must not contribute.
    assign w_coll_all = w_edge | ((r_state == COLLECT) ? r_coll : '0);
    assign w_thr      = (MIN_SCRODS_REQUIRED == '0) ? 32'd1 : 32'(MIN_SCRODS_REQUIRED);
    assign w_meet     = popcount(C_MAX_W'(w_coll_all)) >= w_thr;

    always_comb begin
        w_state_nxt  = r_state;
        w_fire_go    = 1'b0;
        w_collect_go = 1'b0;
        w_expire     = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            IDLE: begin
                if (TRG_SOFT || ((w_edge != '0) && w_meet)) begin
                    w_fire_go = 1'b1;
                end else if (w_edge != '0) begin
                    if (WINDOW == '0) begin
                        w_miss = 1'b1;
                    end else begin
                        w_collect_go = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (TRG_SOFT || w_meet) begin
                    w_fire_go = 1'b1;
                end else if (r_win_cnt == '0) begin
                    w_expire = 1'b1;
                end
            end
            FIRE: begin
                if (r_pulse_cnt == '0) begin
                    w_state_nxt = (HOLDOFF == '0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_fire_go) begin
            w_state_nxt = FIRE;
        end else if (w_collect_go) begin
            w_state_nxt = COLLECT;
        end else if (w_expire || w_miss) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_ack_q       <= '0;
            r_coll        <= '0;
            r_trg_mask    <= '0;
            r_ack_latched <= '0;
            r_win_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_pulse_cnt   <= '0;
        end else begin
            r_ack_q <= ACK;
            case (r_state)
                IDLE: begin
                    if (w_collect_go) begin
                        r_coll    <= w_edge;
                        // Counter reaches zero on the last accepted cycle k+WINDOW.
                        r_win_cnt <= WINDOW - 1'b1;
                    end
                end
                COLLECT: begin
                    r_coll    <= w_coll_all;
                    r_win_cnt <= r_win_cnt - 1'b1;
                end
                FIRE: begin
                    if (r_pulse_cnt != '0) begin
                        r_pulse_cnt <= r_pulse_cnt - 1'b1;
                    end else begin
                        r_hold_cnt <= HOLDOFF - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_fire_go) begin
                r_trg_mask  <= TRG_MASK;
                r_pulse_cnt <= C_PULSE_W'(TRG_LEN - 1);
            end
            if (w_fire_go || w_expire || w_miss) begin
                r_ack_latched <= w_coll_all;
            end
            r_state <= w_state_nxt;
        end
    end

    assign TRG         = (r_state == FIRE) ? r_trg_mask : '0;
    assign TRG_BUSY    = (r_state != IDLE);
    assign ACK_LATCHED = r_ack_latched;

    trig_sat_counter #(
        .STAT_W (STAT_W)
    ) u_stat_cnt (
        .clk     (CLK_80MHZ),
        .rst     (RESET),
        .i_inc   (w_fire_go),
        .o_count (TRG_STATISTICS)
    );

`ifdef TRG_REJECT_CNT_EN
    trig_sat_counter #(
        .STAT_W (STAT_W)
    ) u_reject_cnt (
        .clk     (CLK_80MHZ),
        .rst     (RESET),
        .i_inc   (w_expire | w_miss),
        .o_count (TRG_REJECTS)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_trig_coinc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_coinc_gen
// Description : Directed self-checking bench for trig_coinc_gen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trig_coinc_gen;

    localparam int unsigned N_CH   = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned WIN_W  = 4;
    localparam int unsigned HOLD_W = 16;
    localparam int unsigned STAT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   ack;
    logic [N_CH-1:0]   trg_mask;
    logic [CNT_W-1:0]  min_req;
    logic [WIN_W-1:0]  window;
    logic [HOLD_W-1:0] holdoff;
    logic              trg_soft;
    logic [N_CH-1:0]   trg;
    logic              trg_busy;
    logic [N_CH-1:0]   ack_latched;
    logic [STAT_W-1:0] trg_stat;
`ifdef TRG_REJECT_CNT_EN
    logic [STAT_W-1:0] trg_rej;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    trig_coinc_gen #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W),
        .TRG_LEN (4),
        .HOLD_W  (HOLD_W),
        .STAT_W  (STAT_W)
    ) dut (
        .CLK_80MHZ           (clk),
        .RESET               (rst),
        .ACK                 (ack),
        .TRG_MASK            (trg_mask),
        .MIN_SCRODS_REQUIRED (min_req),
        .WINDOW              (window),
        .HOLDOFF             (holdoff),
        .TRG_SOFT            (trg_soft),
        .TRG                 (trg),
        .TRG_BUSY            (trg_busy),
        .ACK_LATCHED         (ack_latched),
`ifdef TRG_REJECT_CNT_EN
        .TRG_REJECTS         (trg_rej),
`endif
        .TRG_STATISTICS      (trg_stat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!trg_busy) break;
            tick();
        end
        check("idle_timeout", 64'(trg_busy), 64'd0);
    endtask

    task automatic soft_pulse();
        trg_soft = 1'b1;
        tick();
        trg_soft = 1'b0;
    endtask

    task automatic check_rej(input string tag, input int exp);
`ifdef TRG_REJECT_CNT_EN
        check(tag, 64'(trg_rej), 64'(exp));
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        ack      = '0;
        trg_mask = 16'h000F;
        min_req  = 5'd4;
        window   = 4'd3;
        holdoff  = 16'd2;
        trg_soft = 1'b0;
        tick(2);
        check("rst_trg",  64'(trg),         64'h0);
        check("rst_busy", 64'(trg_busy),    64'h0);
        check("rst_lat",  64'(ack_latched), 64'h0);
        check("rst_stat", 64'(trg_stat),    64'h0);
        check_rej("rst_rej", 0);
        rst = 1'b0;
        tick();

        // All four in one cycle: 1-clock latency, 4-clock pulse, 2-clock holdoff
        ack = 16'h000F;
        tick();
        check("t1_trg",  64'(trg),         64'h000F);
        check("t1_stat", 64'(trg_stat),    64'd1);
        check("t1_lat",  64'(ack_latched), 64'h000F);
        tick(3);
        check("t1_trg_c4", 64'(trg), 64'h000F);
        tick();
        check("t1_trg_off",  64'(trg),      64'h0);
        check("t1_hold",     64'(trg_busy), 64'd1);
        tick();
        check("t1_hold2",    64'(trg_busy), 64'd1);
        tick();
        check("t1_idle",     64'(trg_busy), 64'd0);
        ack = '0;
        tick();

        // Staggered edges, 4th at +3 fires
        ack = 16'h0001; tick();
        ack = 16'h0003; tick();
        ack = 16'h0007; tick();
        check("t2_no_trg", 64'(trg), 64'h0);
        ack = 16'h000F; tick();
        check("t2_trg",  64'(trg),         64'h000F);
        check("t2_stat", 64'(trg_stat),    64'd2);
        wait_idle();
        ack = '0;
        tick();

        // 4th edge at +4 falls outside the window
        ack = 16'h0001; tick();
        ack = 16'h0003; tick();
        ack = 16'h0007; tick(2);
        check("t2b_exp_busy", 64'(trg_busy),    64'd0);
        check("t2b_lat",      64'(ack_latched), 64'h0007);
        check_rej("t2b_rej", 1);
        ack = 16'h000F; tick();
        check("t2b_no_trg", 64'(trg), 64'h0);
        ack = '0;
        wait_idle();
        check("t2b_stat", 64'(trg_stat), 64'd2);
        check_rej("t2b_rej2", 2);

        // Unmasked bit4 does not count
        ack = 16'h001E; tick(5);
        check("t3_stat", 64'(trg_stat),    64'd2);
        check("t3_lat",  64'(ack_latched), 64'h000E);
        check_rej("t3_rej", 3);
        ack = '0; tick();
        ack = 16'h000F; tick(10);
        check("t3_held_stat", 64'(trg_stat), 64'd3);
        check("t3_held_busy", 64'(trg_busy), 64'd0);
        ack = '0; tick();

        // Software trigger, then soft and edges ignored during a long holdoff
        holdoff = 16'd20;
        soft_pulse();
        check("t4_trg",  64'(trg),         64'h000F);
        check("t4_stat", 64'(trg_stat),    64'd4);
        check("t4_lat",  64'(ack_latched), 64'h0);
        tick(4);
        check("t4_hold", 64'(trg_busy), 64'd1);
        ack = 16'h000F;
        soft_pulse();
        check("t4_hold_trg", 64'(trg), 64'h0);
        wait_idle();
        check("t4_hold_stat", 64'(trg_stat), 64'd4);
        holdoff = 16'd2;
        ack = '0; tick();

        // Soft plus threshold edge in the same cycle fires once
        ack = 16'h000F;
        soft_pulse();
        check("t4b_trg", 64'(trg), 64'h000F);
        wait_idle();
        check("t4b_stat", 64'(trg_stat), 64'd5);
        ack = '0; tick();

        // Reset mid-pulse
        soft_pulse();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_trg",  64'(trg),      64'h0);
        check("t5_stat", 64'(trg_stat), 64'd0);
        check("t5_busy", 64'(trg_busy), 64'd0);
        check_rej("t5_rej", 0);

        // MIN=0 acts as 1, single-cycle window on the top channel
        trg_mask = 16'hFFFF;
        min_req  = 5'd0;
        window   = 4'd0;
        ack = 16'h8000; tick();
        check("t6_trg", 64'(trg),         64'hFFFF);
        check("t6_lat", 64'(ack_latched), 64'h8000);
        wait_idle();
        ack = '0; tick();
        min_req = 5'd2;
        ack = 16'h0001; tick();
        check("t6_miss_busy", 64'(trg_busy),    64'd0);
        check("t6_miss_lat",  64'(ack_latched), 64'h0001);
        check_rej("t6_rej", 1);
        ack = '0; tick();

        // Threshold above mask population: edges cannot fire
        trg_mask = 16'h0003;
        min_req  = 5'd3;
        ack = 16'h0003; tick(2);
        check("t6_unreach_stat", 64'(trg_stat), 64'd1);
        check_rej("t6_rej2", 2);
        ack = '0; tick();

        // HOLDOFF=0 returns straight to IDLE, then saturate the counter
        holdoff = 16'd0;
        soft_pulse();
        tick(4);
        check("t7_h0_busy", 64'(trg_busy), 64'd0);
        for (int i = 0; i < 260; i++) begin
            soft_pulse();
            wait_idle();
        end
        check("t7_sat", 64'(trg_stat), 64'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
